pcie_tx_arbiter: RTL and testbench

- Packet-granular arbiter that shares the single 64-bit TRN transmit interface of the Virtex-6 PCIe endpoint core between NUM_REQ TLP sources.
- Typical sources: completion engine (req 0), DMA write engine, DMA read-request engine.
- Sits between the user TLP engines and the endpoint block inside the ml605_pcie design.
- Never interleaves beats of different TLPs, and only starts a TLP when the core reports a free TX buffer and the link is up.

---
 rtl/pcie_tx_pkg.sv | 11 +
 rtl/pcie_tx_arbiter_if.sv | 35 +++
 rtl/pcie_rr_arbiter.sv | 30 +++
 rtl/pcie_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pcie_tx_pkg.sv
// Shared constants and FSM state type for the PCIe TRN transmit arbiter.
package pcie_tx_pkg;
  localparam int TRN_DW  = 64;
  localparam int MAX_REQ = 8;
  localparam int GID_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;
endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// Requester-side and TRN-side signals of the transmit arbiter.
// master = the arbiter, slave = requesters plus endpoint core.
interface pcie_tx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 64
);
  logic [NUM_REQ*DW-1:0] req_td;
  logic [NUM_REQ-1:0]    req_rem;
  logic [NUM_REQ-1:0]    req_sof;
  logic [NUM_REQ-1:0]    req_eof;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DW-1:0]         trn_td;
  logic                  trn_trem_n;
  logic                  trn_tsof_n;
  logic                  trn_teof_n;
  logic                  trn_tsrc_rdy_n;
  logic                  trn_tdst_rdy_n;
  logic [5:0]            trn_tbuf_av;
  logic                  trn_lnk_up_n;

  modport master (
    input  req_td, req_rem, req_sof, req_eof, req_valid,
    output req_ready,
    output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  trn_tdst_rdy_n, trn_tbuf_av, trn_lnk_up_n
  );

  modport slave (
    output req_td, req_rem, req_sof, req_eof, req_valid,
    input  req_ready,
    input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output trn_tdst_rdy_n, trn_tbuf_av, trn_lnk_up_n
  );
endinterface

// File: rtl/pcie_rr_arbiter.sv
// Rotate-priority encoder: picks the first eligible requester after rr_ptr, with wrap.
module pcie_rr_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [GID_W-1:0]   rr_ptr,
  output logic [GID_W-1:0]   grant,
  output logic               any
);
  int off;
  int best;

  // Distance of lane j past rr_ptr; the smallest distance wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    off   = 0;
    best  = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      off = (j + 2*NUM_REQ - 1 - int'(rr_ptr)) % NUM_REQ;
      if (eligible[j] && (!any || off < best)) begin
        any   = 1'b1;
        best  = off;
        grant = GID_W'(j);
      end
    end
  end
endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular arbiter sharing the 64-bit TRN TX port between NUM_REQ TLP sources.
// Define PCIE_TX_CPL_PRIORITY_EN to give requester 0 strict priority at each grant.
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MIN_TBUF_AV = 1,
  parameter int DW          = TRN_DW
) (
  input  logic               sys_clk,
  input  logic               sys_reset_n,
  pcie_tx_arbiter_if.master  bus,
  output logic [GID_W-1:0]   grant_id,
  output logic               busy,
  output logic               proto_err
);
  localparam logic [5:0] MIN_AV = 6'(MIN_TBUF_AV);

  state_t                        state;
  logic [GID_W-1:0]              rr_ptr;
  logic                          first_beat;
  logic [NUM_REQ-1:0][DW-1:0]    lane_td;
  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            grant_oh;
  logic [GID_W-1:0]              rr_gnt;
  logic [GID_W-1:0]              next_gid;
  logic                          rr_any;
  logic                          ptr_upd;
  logic                          gate;
  logic [DW-1:0]                 sel_td;
  logic                          sel_valid, sel_sof, sel_eof, sel_rem;
  logic                          beat;

  assign lane_td  = bus.req_td;
  assign gate     = ~bus.trn_lnk_up_n & (bus.trn_tbuf_av >= MIN_AV);
  assign eligible = bus.req_valid & bus.req_sof & {NUM_REQ{gate}};

  pcie_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (rr_gnt),
    .any      (rr_any)
  );

`ifdef PCIE_TX_CPL_PRIORITY_EN
  // Completions jump the queue but leave the round-robin order untouched.
  assign next_gid = eligible[0] ? '0 : rr_gnt;
  assign ptr_upd  = ~eligible[0];
`else
  assign next_gid = rr_gnt;
  assign ptr_upd  = 1'b1;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign grant_oh[i] = (state == XFER) && (grant_id == GID_W'(i));
  end

  always_comb begin
    sel_td    = '0;
    sel_valid = 1'b0;
    sel_sof   = 1'b0;
    sel_eof   = 1'b0;
    sel_rem   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_td    = lane_td[i];
        sel_valid = bus.req_valid[i];
        sel_sof   = bus.req_sof[i];
        sel_eof   = bus.req_eof[i];
        sel_rem   = bus.req_rem[i];
      end
    end
  end

  // Pass-through of the owning lane; with no owner everything sits at reset values.
  assign bus.trn_td         = sel_td;
  assign bus.trn_tsrc_rdy_n = ~sel_valid;
  assign bus.trn_tsof_n     = ~sel_sof;
  assign bus.trn_teof_n     = ~sel_eof;
  assign bus.trn_trem_n     = (state == XFER) ? sel_rem : 1'b1;
  assign bus.req_ready      = grant_oh & {NUM_REQ{~bus.trn_tdst_rdy_n}};
  assign beat               = (state == XFER) & sel_valid & ~bus.trn_tdst_rdy_n;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state      <= IDLE;
      rr_ptr     <= GID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      busy       <= 1'b0;
      first_beat <= 1'b0;
      proto_err  <= 1'b0;
    end else if (bus.trn_lnk_up_n) begin
      // Link loss abandons the packet; rr_ptr and the sticky error survive.
      state      <= IDLE;
      grant_id   <= '0;
      busy       <= 1'b0;
      first_beat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_any) begin
            state      <= XFER;
            grant_id   <= next_gid;
            busy       <= 1'b1;
            first_beat <= 1'b1;
            if (ptr_upd) rr_ptr <= next_gid;
          end
        end
        XFER: begin
          if (beat) begin
            first_beat <= 1'b0;
            if (first_beat && !sel_sof) proto_err <= 1'b1;
            if (sel_eof) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed table-driven bench for pcie_tx_arbiter plus link-down, priority,
// protocol-error and async-reset sequences.
module tb_pcie_tx_arbiter;
  import pcie_tx_pkg::*;

  localparam int N = 3;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n;
  logic [2:0] grant_id;
  logic       busy;
  logic       proto_err;

  pcie_tx_arbiter_if #(.NUM_REQ(N), .DW(64)) bus ();

  pcie_tx_arbiter #(.NUM_REQ(N), .MIN_TBUF_AV(1), .DW(64)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .bus         (bus.master),
    .grant_id    (grant_id),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] valid, sof, eof;
    logic       dst_n;
    logic [5:0] av;
    logic       src_n, sof_n, eof_n;
    logic [2:0] rdy;
    logic [2:0] gid;
    logic       busy;
    logic [3:0] lane;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] lane_td(int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 | 32'(i)};
  endfunction

  function automatic vec_t mk(logic [2:0] v, logic [2:0] s, logic [2:0] e, logic d,
                              logic [5:0] a, logic sn, logic sfn, logic efn,
                              logic [2:0] r, logic [2:0] g, logic b, logic [3:0] l);
    vec_t t;
    t.valid = v; t.sof = s; t.eof = e; t.dst_n = d; t.av = a;
    t.src_n = sn; t.sof_n = sfn; t.eof_n = efn; t.rdy = r; t.gid = g; t.busy = b; t.lane = l;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] v, logic [2:0] s, logic [2:0] e);
    bus.req_valid = v;
    bus.req_sof   = s;
    bus.req_eof   = e;
    bus.req_rem   = e;
  endtask

  task automatic chk_quiet(string name);
    chk({name, "_ctl"}, 64'({bus.trn_tsrc_rdy_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_trem_n}), 64'hF);
    chk({name, "_td"},   bus.trn_td, 64'h0);
    chk({name, "_rdy"},  64'(bus.req_ready), 64'h0);
    chk({name, "_gid"},  64'(grant_id), 64'h0);
    chk({name, "_busy"}, 64'(busy), 64'h0);
  endtask

  logic [2:0] prio_exp [4];

  initial begin
    sys_reset_n = 1'b0;
    for (int i = 0; i < N; i++) bus.req_td[i*64 +: 64] = lane_td(i);
    drive(3'b000, 3'b000, 3'b000);
    bus.trn_tdst_rdy_n = 1'b0;
    bus.trn_tbuf_av    = 6'd4;
    bus.trn_lnk_up_n   = 1'b0;

    repeat (2) @(negedge sys_clk);
    #1;
    chk_quiet("reset");
    chk("reset_perr", 64'(proto_err), 64'h0);
    sys_reset_n = 1'b1;

`ifndef PCIE_TX_CPL_PRIORITY_EN
    // All three sources streaming 2-beat TLPs: grants 0,1,2,0 with one bubble each.
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd0, 0, 4'd8));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 0, 0, 1, 3'b001, 3'd0, 1, 4'd0));
    tbl.push_back(mk(3'b111, 3'b110, 3'b001, 0, 6'd4, 0, 1, 0, 3'b001, 3'd0, 1, 4'd0));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd0, 0, 4'd8));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 0, 0, 1, 3'b010, 3'd1, 1, 4'd1));
    tbl.push_back(mk(3'b111, 3'b101, 3'b010, 0, 6'd4, 0, 1, 0, 3'b010, 3'd1, 1, 4'd1));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd1, 0, 4'd8));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 0, 0, 1, 3'b100, 3'd2, 1, 4'd2));
    tbl.push_back(mk(3'b111, 3'b011, 3'b100, 0, 6'd4, 0, 1, 0, 3'b100, 3'd2, 1, 4'd2));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd2, 0, 4'd8));
    tbl.push_back(mk(3'b111, 3'b111, 3'b000, 0, 6'd4, 0, 0, 1, 3'b001, 3'd0, 1, 4'd0));
    tbl.push_back(mk(3'b111, 3'b110, 3'b001, 0, 6'd4, 0, 1, 0, 3'b001, 3'd0, 1, 4'd0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd0, 0, 4'd8));
`endif
    // Requester 1, 3-beat TLP.
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd0, 0, 4'd8));
    tbl.push_back(mk(3'b010, 3'b010, 3'b000, 0, 6'd4, 0, 0, 1, 3'b010, 3'd1, 1, 4'd1));
    tbl.push_back(mk(3'b010, 3'b000, 3'b000, 0, 6'd4, 0, 1, 1, 3'b010, 3'd1, 1, 4'd1));
    tbl.push_back(mk(3'b010, 3'b000, 3'b010, 0, 6'd4, 0, 1, 0, 3'b010, 3'd1, 1, 4'd1));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 0, 6'd4, 1, 1, 1, 3'b000, 3'd1, 0, 4'd8));
    // No TX buffers: hold off; buffers ignored once in flight; valid gap; dst stall.
    tbl.push_back(mk(3'b100, 3'b100, 3'b000, 0, 6'd0, 1, 1, 1, 3'b000, 3'd1, 0, 4'd8));
    tbl.push_back(mk(3'b100, 3'b100, 3'b000, 0, 6'd0, 1, 1, 1, 3'b000, 3'd1, 0, 4'd8));
    tbl.push_back(mk(3'b100, 3'b100, 3'b000, 0, 6'd1, 1, 1, 1, 3'b000, 3'd1, 0, 4'd8));
    tbl.push_back(mk(3'b100, 3'b100, 3'b000, 0, 6'd0, 0, 0, 1, 3'b100, 3'd2, 1, 4'd2));
    tbl.push_back(mk(3'b001, 3'b001, 3'b000, 0, 6'd0, 1, 1, 1, 3'b100, 3'd2, 1, 4'd2));
    tbl.push_back(mk(3'b101, 3'b001, 3'b100, 1, 6'd0, 0, 1, 0, 3'b000, 3'd2, 1, 4'd2));
    tbl.push_back(mk(3'b101, 3'b001, 3'b100, 0, 6'd0, 0, 1, 0, 3'b100, 3'd2, 1, 4'd2));
    // Single-beat TLP from requester 0.
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, 0, 6'd1, 1, 1, 1, 3'b000, 3'd2, 0, 4'd8));
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, 0, 6'd1, 0, 0, 0, 3'b001, 3'd0, 1, 4'd0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 0, 6'd1, 1, 1, 1, 3'b000, 3'd0, 0, 4'd8));

    foreach (tbl[k]) begin
      @(negedge sys_clk);
      drive(tbl[k].valid, tbl[k].sof, tbl[k].eof);
      bus.trn_tdst_rdy_n = tbl[k].dst_n;
      bus.trn_tbuf_av    = tbl[k].av;
      #1;
      chk($sformatf("row%0d_ctl", k),
          64'({bus.trn_tsrc_rdy_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_trem_n}),
          64'({tbl[k].src_n, tbl[k].sof_n, tbl[k].eof_n, tbl[k].busy ? ~tbl[k].eof_n : 1'b1}));
      chk($sformatf("row%0d_rdy", k),  64'(bus.req_ready), 64'(tbl[k].rdy));
      chk($sformatf("row%0d_gid", k),  64'(grant_id), 64'(tbl[k].gid));
      chk($sformatf("row%0d_busy", k), 64'(busy), 64'(tbl[k].busy));
      chk($sformatf("row%0d_td", k),   bus.trn_td, (tbl[k].lane == 4'd8) ? 64'h0 : lane_td(int'(tbl[k].lane)));
    end
    chk("table_perr", 64'(proto_err), 64'h0);

    // Link drops during beat 2 of a 4-beat TLP from requester 1.
    @(negedge sys_clk);
    drive(3'b010, 3'b010, 3'b000);
    bus.trn_tbuf_av = 6'd4;
    @(negedge sys_clk);
    #1;
    chk("lnk_gid", 64'(grant_id), 64'd1);
    chk("lnk_busy", 64'(busy), 64'd1);
    @(negedge sys_clk);
    drive(3'b010, 3'b000, 3'b000);
    bus.trn_lnk_up_n = 1'b1;
    @(negedge sys_clk);
    drive(3'b010, 3'b010, 3'b000);
    #1;
    chk_quiet("lnkdown");
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      #1;
      chk($sformatf("lnkdown_hold%0d", c),
          64'({bus.trn_tsrc_rdy_n, busy}), 64'({1'b1, 1'b0}));
    end
    @(negedge sys_clk);
    drive(3'b000, 3'b000, 3'b000);
    bus.trn_lnk_up_n = 1'b0;

    // Requesters 0 and 1 continuously offering single-beat TLPs.
`ifdef PCIE_TX_CPL_PRIORITY_EN
    prio_exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`else
    prio_exp = '{3'd0, 3'd1, 3'd0, 3'd1};
`endif
    @(negedge sys_clk);
    drive(3'b011, 3'b011, 3'b011);
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      #1;
      chk($sformatf("prio%0d_gid", k), 64'(grant_id), 64'(prio_exp[k]));
      chk($sformatf("prio%0d_busy", k), 64'(busy), 64'd1);
      @(negedge sys_clk);
    end
    drive(3'b000, 3'b000, 3'b000);

    // First granted beat loses sof -> sticky proto_err; then async reset mid-packet.
    @(negedge sys_clk);
    drive(3'b100, 3'b100, 3'b000);
    @(negedge sys_clk);
    drive(3'b100, 3'b000, 3'b000);
    #1;
    chk("perr_before", 64'(proto_err), 64'h0);
    @(negedge sys_clk);
    #1;
    chk("perr_set", 64'(proto_err), 64'h1);
    chk("perr_busy", 64'(busy), 64'h1);
    @(negedge sys_clk);
    #1;
    chk("perr_sticky", 64'(proto_err), 64'h1);
    #1;
    sys_reset_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_perr", 64'(proto_err), 64'h0);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    drive(3'b000, 3'b000, 3'b000);
    @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
